// File: rtl/sched_pkg.sv
// Shared types and constants for the denoise frame scheduler.
// State encoding, block geometry and default frame parameters.
package sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int BLK_W  = 72;
  localparam int BLKS   = 4;
  localparam int DATA_W = BLK_W * BLKS;

  localparam int ROWS_DEF  = 160;
  localparam int COLS_DEF  = 53;
  localparam int PRIME_DEF = 2;
  localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous result FIFO between denoise and HOG.
// Head data reads as zero while empty.
module sched_fifo
  import sched_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr,
  input  logic [W-1:0]                 wdata,
  input  logic                         rd,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_wr;
  logic          do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd & ~empty;
  // a write into a full FIFO is only taken when the head leaves
  assign do_wr = wr & (~full | do_rd);
  assign rdata = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= ptr_inc(wp);
      if (do_rd) rp <= ptr_inc(rp);
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wdata;
  end

endmodule

// File: rtl/denoise_sched.sv
// Frame controller: credit-paced pixel intake, result FIFO, HOG tagging.
// Define DENOISE_SCHED_PERF_EN to add the perf_stall counter port.
module denoise_sched
  import sched_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  parameter int PRIME = PRIME_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    src_valid,
  output logic                    src_ready,
  output logic                    dn_en,
  input  logic                    dn_valid,
  input  logic [BLKS*BLK_W-1:0]   dn_blk,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLKS*BLK_W-1:0]   out_blk,
  output logic [7:0]              cnt_row,
  output logic [5:0]              cnt_col,
`ifdef DENOISE_SCHED_PERF_EN
  output logic [31:0]             perf_stall,
`endif
  output logic                    ovf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [15:0]   PRIME_LAST = 16'(PRIME - 1);
  localparam logic [15:0]   RUN_LAST   = 16'(ROWS * COLS - 1);
  localparam logic [7:0]    ROW_LAST   = 8'(ROWS - 1);
  localparam logic [5:0]    COL_LAST   = 6'(COLS - 1);
  localparam logic [CW-1:0] CRED_MAX   = CW'(DEPTH);

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   beat;
  logic [CW-1:0] credits;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          hs;
  logic          take;
  logic          wr;
  logic          last_pos;
  logic          go;

  assign hs       = out_valid & out_ready;
  assign dn_en    = src_valid & src_ready;
  assign take     = dn_en & (state == S_RUN);
  assign wr       = dn_valid & (state != S_IDLE);
  assign last_pos = (cnt_row == ROW_LAST) && (cnt_col == COL_LAST);
  assign go       = (state == S_IDLE) & start;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign out_valid = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    src_ready = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = (PRIME == 0) ? S_RUN : S_PRIME;
      end
      S_PRIME: begin
        src_ready = 1'b1;
        if (src_valid && beat == PRIME_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        src_ready = (credits != '0);
        if (dn_en && beat == RUN_LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (hs && last_pos && fifo_cnt == CW'(1)) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // the phase boundary beat is exactly the one that changes state
  always_ff @(posedge clk) begin
    if (!rst_n || state == S_IDLE) beat <= '0;
    else if (dn_en) beat <= (state_nxt != state) ? '0 : beat + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || state == S_IDLE) begin
      credits <= CRED_MAX;
    end else begin
      case ({take, hs})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   if (credits != CRED_MAX) credits <= credits + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || state == S_IDLE) begin
      cnt_row <= '0;
      cnt_col <= '0;
    end else if (hs) begin
      if (cnt_col == COL_LAST) begin
        cnt_col <= '0;
        cnt_row <= (cnt_row == ROW_LAST) ? '0 : cnt_row + 1'b1;
      end else begin
        cnt_col <= cnt_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || go) ovf <= 1'b0;
    else if (wr && fifo_full && !hs) ovf <= 1'b1;
  end

`ifdef DENOISE_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n || go) begin
      perf_stall <= '0;
    end else if ((state == S_PRIME || state == S_RUN) &&
                 src_valid && !src_ready && perf_stall != '1) begin
      perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

  sched_fifo #(
    .W     (BLKS * BLK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wr),
    .wdata (dn_blk),
    .rd    (out_ready),
    .rdata (out_blk),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_denoise_sched.sv
// Directed bench for denoise_sched with a small denoise pipeline model.
// Frame 4x3, PRIME 2, DEPTH 4.
module tb_denoise_sched;
  import sched_pkg::*;

  localparam int ROWS  = 4;
  localparam int COLS  = 3;
  localparam int PRIME = 2;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              src_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              inj = 1'b0;
  logic              busy, done, src_ready, dn_en, dn_valid, out_valid, ovf;
  logic [DATA_W-1:0] dn_blk, out_blk;
  logic [7:0]        cnt_row;
  logic [5:0]        cnt_col;
`ifdef DENOISE_SCHED_PERF_EN
  logic [31:0]       perf_stall;
`endif

  always #5 clk = ~clk;

  denoise_sched #(
    .ROWS(ROWS), .COLS(COLS), .PRIME(PRIME), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .src_valid(src_valid), .src_ready(src_ready), .dn_en(dn_en),
    .dn_valid(dn_valid), .dn_blk(dn_blk),
    .out_valid(out_valid), .out_ready(out_ready), .out_blk(out_blk),
    .cnt_row(cnt_row), .cnt_col(cnt_col),
`ifdef DENOISE_SCHED_PERF_EN
    .perf_stall(perf_stall),
`endif
    .ovf(ovf)
  );

  function automatic logic [DATA_W-1:0] blk_of(input int k);
    return {72'(k + 3000), 72'(k + 2000), 72'(k + 1000), 72'(k)};
  endfunction

  // denoise model: results reach the FIFO input two cycles after dn_en
  int                m_cnt = 0;
  logic              v0 = 1'b0;
  logic              v1 = 1'b0;
  logic [DATA_W-1:0] b0 = '0;
  logic [DATA_W-1:0] b1 = '0;

  always @(posedge clk) begin
    if (start && !busy) m_cnt <= 0;
    else if (dn_en) m_cnt <= m_cnt + 1;
    v0 <= dn_en && (m_cnt >= PRIME);
    b0 <= blk_of(m_cnt - PRIME);
    v1 <= v0;
    b1 <= b0;
  end

  assign dn_valid = v1 | inj;
  assign dn_blk   = b1;

  int n_chk = 0;
  int n_fail = 0;
  int n_beat, n_out, n_done, cyc_n;
  int first_beat_cyc, last_beat_cyc, last_out_cyc, done_cyc;

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // observe the cycle ahead of the next posedge, then move to the next negedge
  task automatic cyc();
    #1;
    cyc_n++;
    if (src_valid && src_ready) begin
      if (n_beat == 0) first_beat_cyc = cyc_n;
      last_beat_cyc = cyc_n;
      n_beat++;
    end
    if (out_valid && out_ready) begin
      chk_i("out_row", int'(cnt_row), n_out / COLS);
      chk_i("out_col", int'(cnt_col), n_out % COLS);
      chk_b("out_blk", out_blk, blk_of(n_out));
      last_out_cyc = cyc_n;
      n_out++;
    end
    if (done) begin
      done_cyc = cyc_n;
      n_done++;
    end
    @(negedge clk);
  endtask

  task automatic begin_frame();
    n_beat = 0; n_out = 0; n_done = 0; cyc_n = 0;
    first_beat_cyc = -1; last_beat_cyc = -1;
    last_out_cyc = -1; done_cyc = -1;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      cyc();
      k++;
    end
    chk_i("done_seen", int'(n_done != 0), 1);
    #1;
    chk_i("busy_after_done", int'(busy), 0);
    chk_i("done_one_cycle", int'(done), 0);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_i({tag, "_busy"}, int'(busy), 0);
    chk_i({tag, "_done"}, int'(done), 0);
    chk_i({tag, "_src_ready"}, int'(src_ready), 0);
    chk_i({tag, "_dn_en"}, int'(dn_en), 0);
    chk_i({tag, "_out_valid"}, int'(out_valid), 0);
    chk_b({tag, "_out_blk"}, out_blk, '0);
    chk_i({tag, "_cnt_row"}, int'(cnt_row), 0);
    chk_i({tag, "_cnt_col"}, int'(cnt_col), 0);
    chk_i({tag, "_ovf"}, int'(ovf), 0);
  endtask

  initial begin
    src_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // free-flow
    out_ready = 1'b1;
    begin_frame();
    run_until_done(60);
    chk_i("ff_beats", n_beat, 14);
    chk_i("ff_first_beat", first_beat_cyc, 2);
    chk_i("ff_last_beat", last_beat_cyc, 15);
    chk_i("ff_outs", n_out, 12);
    chk_i("ff_last_out", last_out_cyc, 18);
    chk_i("ff_done", done_cyc, 19);
    chk_i("wrap_row_zero", int'(cnt_row), 0);
    chk_i("wrap_col_zero", int'(cnt_col), 0);
    chk_i("ff_ovf", int'(ovf), 0);

    // backpressure
    out_ready = 1'b0;
    begin_frame();
    repeat (20) cyc();
    #1;
    chk_i("bp_beats", n_beat, PRIME + DEPTH);
    chk_i("bp_src_ready", int'(src_ready), 0);
    chk_i("bp_out_valid", int'(out_valid), 1);
    chk_i("bp_ovf", int'(ovf), 0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    repeat (6) cyc();
    chk_i("bp_one_credit_beats", n_beat, PRIME + DEPTH + 1);
    chk_i("bp_one_credit_outs", n_out, 1);
    out_ready = 1'b1;
    run_until_done(80);
    chk_i("bp_beats_total", n_beat, 14);
    chk_i("bp_outs_total", n_out, 12);
    chk_i("bp_ovf_end", int'(ovf), 0);

    // alternating out_ready: issue and return coincide
    begin_frame();
    for (int k = 0; k < 120 && n_done == 0; k++) begin
      int run;
      out_ready = (k % 2 == 0);
      cyc();
      run = (n_beat > PRIME) ? n_beat - PRIME : 0;
      chk_i("alt_outstanding", int'((run - n_out) <= DEPTH && run >= n_out), 1);
    end
    chk_i("alt_done", int'(n_done != 0), 1);
    chk_i("alt_outs", n_out, 12);
    chk_i("alt_beats", n_beat, 14);
    chk_i("alt_ovf", int'(ovf), 0);
    chk_i("alt_busy_end", int'(busy), 0);

    // reset in the middle of RUN
    out_ready = 1'b1;
    begin_frame();
    for (int k = 0; k < 30 && n_beat < 7; k++) cyc();
    chk_i("mid_beats", n_beat, 7);
    src_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    src_valid = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    inj = 1'b1;
    cyc();
    inj = 1'b0;
    repeat (4) begin
      chk_i("late_dn_valid_ignored", int'(out_valid), 0);
      cyc();
    end
    begin_frame();
    run_until_done(60);
    chk_i("clean_beats", n_beat, 14);
    chk_i("clean_outs", n_out, 12);
    chk_i("clean_done", done_cyc, 19);
    chk_i("clean_ovf", int'(ovf), 0);

    // start pulse while draining
    begin_frame();
    for (int k = 0; k < 40 && n_beat < 14; k++) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_until_done(40);
    repeat (5) cyc();
    chk_i("sb_outs", n_out, 12);
    chk_i("sb_beats", n_beat, 14);
    chk_i("sb_done_count", n_done, 1);
    chk_i("sb_busy", int'(busy), 0);
    chk_i("sb_ovf", int'(ovf), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
